inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder and issue queue: packs separate instruction fields (immediate-select, ALU op, rs, rd, rt, imm) into the 32-bit instruction word consumed by the core's instruction decoder, then issues the words in order over a valid/ready stream. It sits between the test/program source and the decoder, so that any word it emits decodes back to exactly the fields it was given. Field combinations that the word format cannot represent are rejected and counted.

## Interface
- DEPTH, 4, issue FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field set presented
- in_ready  out  1  encoder can accept a field set
- in_ri  in  1  1 = immediate form, 0 = register form
- in_op  in  4  ALU op; 4'b0000 = NOP
- in_rs / in_rd / in_rt  in  6 each  register fields
- in_imm  in  15  immediate
- out_valid  out  1  out_inst holds an instruction
- out_ready  in  1  consumer takes out_inst
- out_inst  out  32  encoded instruction word
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- err  out  1  one-cycle pulse: a field set was rejected
- err_cnt  out  8  saturating rejected-set count
- clr_err  in  1  synchronous clear of err_cnt

## Operation
- Word layout: [31]=ri, [30:25]=A, [24:19]=rd, [18:15]=op, [14:0]=low.
- low = in_imm when ri=1; {in_rt, 9'b0} when ri=0, except ops 1001 and 1011, where low = ri ? in_imm : 15'b0.
- op 0000: canonical NOP, word = 32'h0000_0000 regardless of the other fields; never an error.
- op 1001: A=in_rt; requires in_rs == in_rd, otherwise reject.
- op 1011: A=in_rt; requires in_rs == in_rt, otherwise reject.
- All other ops: A=in_rs; never rejected.
- Accept = in_valid && in_ready. A valid set is encoded combinationally and written to the FIFO tail on the same edge.
- A rejected set is consumed (handshake completes) but is not written to the FIFO.
- On a reject, err is high for the following cycle and err_cnt increments, saturating at 255.
- clr_err sets err_cnt to 0 and takes priority over a simultaneous increment.
- FIFO: circular buffer with wrap-around pointers; pop = out_valid && out_ready.
- Simultaneous push and pop keeps level unchanged.
- in_ready = (level < DEPTH). It is a function of state only and does not depend on out_ready in the same cycle, so a full FIFO stalls even while it is popping.
- out_inst is the head entry. It is held stable while out_valid && !out_ready.
- Reset (asynchronous, any time including mid-transfer) drops all entries.
  - Values after reset: level=0, out_valid=0, out_inst=0, err=0, err_cnt=0, in_ready=1.

## Timing
- Latency: a field set accepted at edge N gives out_valid=1 with its word after edge N.
- Empty FIFO: out_valid=0 (unless NOP fill is enabled) and out_inst=0.
- Throughput: one accept and one issue per cycle.
- Order: issued words leave in accept order. Rejected sets leave no hole and no NOP in the stream.
- err is registered and asserts the cycle after the rejecting accept. Back-to-back rejects keep err high continuously.

## Configuration
- INST_ENC_NOP_FILL_EN defined:
  - When the FIFO is empty, out_valid=1 and out_inst=32'h0000_0000 (NOP, decodes with RegWrite=0).
  - Handshakes on these filler words do not change level.
  - Reset value of out_valid is 1.
- Not defined: out_valid = (level != 0), and nothing is issued while the FIFO is empty.

## Test plan
- Reset, then ri=0, op=0010, rs=3, rd=5, rt=7 with out_ready=1 -> out_inst=32'h0629_0E00 one cycle later; level returns to 0.
- ri=1, op=0011, rs=1, rd=2, imm=15'h1234 -> out_inst=32'h8211_9234.
- op=1001, rs=rd=4, rt=9, ri=0 -> 32'h1224_8000. Then op=1011, rs=6, rt=8 -> no word issued, err pulses for 1 cycle, err_cnt=1. Then clr_err -> err_cnt=0.
- DEPTH=4, out_ready=0, five back-to-back sets -> four accepted, level=4, in_ready=0, fifth set held. Release out_ready -> words issue in order with no loss across pointer wrap.
- 300 consecutive rejects -> err_cnt stops at 255. Assert rst_n low while level=3 -> level=0, out_valid=0 (1 with the macro) asynchronously.
- With INST_ENC_NOP_FILL_EN defined and the FIFO empty -> out_valid=1 and out_inst=0; one push appears on the cycle after accept, ahead of further NOPs.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs instruction fields into 32-bit words and issues them
// in order from a DEPTH-entry FIFO over a valid/ready stream.
// Ports: clk, rst_n; in_valid/in_ready + in_ri, in_op, in_rs, in_rd, in_rt,
// in_imm; out_valid/out_ready + out_inst; level; err, err_cnt, clr_err.
// Option: define INST_ENC_NOP_FILL_EN to present NOP words when empty.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_ri,
  input  logic [3:0]               in_op,
  input  logic [5:0]               in_rs,
  input  logic [5:0]               in_rd,
  input  logic [5:0]               in_rt,
  input  logic [14:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err,
  output logic [7:0]               err_cnt,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  logic [5:0]  a;
  logic [14:0] low;
  logic [31:0] word;
  logic        bad;
  logic        acc;
  logic        push;
  logic        pop;

  always_comb begin
    a    = in_rs;
    low  = in_ri ? in_imm : {in_rt, 9'b0};
    bad  = 1'b0;
    word = 32'h0;
    unique case (1'b1)
      (in_op == 4'b0000): begin
        low = 15'h0;
      end
      (in_op == 4'b1001): begin
        a   = in_rt;
        low = in_ri ? in_imm : 15'h0;
        bad = (in_rs != in_rd);
      end
      (in_op == 4'b1011): begin
        a   = in_rt;
        low = in_ri ? in_imm : 15'h0;
        bad = (in_rs != in_rt);
      end
      default: ;
    endcase
    // NOP is canonical: all-zero word whatever the other fields hold
    if (in_op != 4'b0000)
      word = {in_ri, a, in_rd, in_op, low};
  end

  assign in_ready = (cnt != FULL);
  assign acc      = in_valid && in_ready;
  assign push     = acc && !bad;
  // filler NOPs never consume an entry
  assign pop      = (cnt != '0) && out_ready;
  assign level    = cnt;
  assign out_inst = (cnt != '0) ? mem[rd_ptr] : 32'h0;

`ifdef INST_ENC_NOP_FILL_EN
  assign out_valid = 1'b1;
`else
  assign out_valid = (cnt != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'h0;
    end else if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= 8'h0;
    end else begin
      err <= acc && bad;
      if (clr_err)
        err_cnt <= 8'h0;
      else if (acc && bad && err_cnt != 8'hff)
        err_cnt <= err_cnt + 8'h1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench for inst_encoder.
// Directed vectors plus randomized field sets against a reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_ri = 1'b0;
  logic [3:0]  in_op = 4'h0;
  logic [5:0]  in_rs = 6'h0;
  logic [5:0]  in_rd = 6'h0;
  logic [5:0]  in_rt = 6'h0;
  logic [14:0] in_imm = 15'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [2:0]  level;
  logic        err;
  logic [7:0]  err_cnt;
  logic        clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int mcnt = 0;
  bit rand_rdy = 1'b0;
  logic [31:0] expq [$];

  inst_encoder #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ri(in_ri), .in_op(in_op),
    .in_rs(in_rs), .in_rd(in_rd), .in_rt(in_rt),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .level(level),
    .err(err), .err_cnt(err_cnt), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: word built from the field rules with plain arithmetic
  function automatic void ref_enc(
    input logic ri, input logic [3:0] op,
    input logic [5:0] rs, input logic [5:0] rd, input logic [5:0] rt,
    input logic [14:0] imm,
    output logic [31:0] w, output bit bad);
    longint a, low, v;
    bad = 0;
    w = 32'h0;
    if (op == 0) return;
    if (op == 9 || op == 11) begin
      a = rt;
      low = ri ? longint'(imm) : 0;
      bad = (op == 9) ? (rs != rd) : (rs != rt);
    end else begin
      a = rs;
      low = ri ? longint'(imm) : longint'(rt) * 512;
    end
    v = longint'(ri) * 64'h8000_0000 + a * (1 << 25)
      + longint'(rd) * (1 << 19) + longint'(op) * (1 << 15) + low;
    w = v[31:0];
  endfunction

  task automatic drive(logic ri, logic [3:0] op, logic [5:0] rs,
                       logic [5:0] rd, logic [5:0] rt, logic [14:0] imm);
    in_ri = ri; in_op = op; in_rs = rs;
    in_rd = rd; in_rt = rt; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // waits for the handshake, then records the expected response
  task automatic finish_send(logic [31:0] w, bit bad);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
      return;
    end
    if (bad) begin
      if (mcnt < 255) mcnt++;
    end else begin
      expq.push_back(w);
    end
    chk("err_pulse", {31'h0, err}, {31'h0, bad});
    chk("err_cnt", {24'h0, err_cnt}, mcnt);
  endtask

  task automatic send_exp(logic ri, logic [3:0] op, logic [5:0] rs,
                          logic [5:0] rd, logic [5:0] rt,
                          logic [14:0] imm, logic [31:0] w, bit bad);
    drive(ri, op, rs, rd, rt, imm);
    finish_send(w, bad);
  endtask

  task automatic send_rand();
    logic ri; logic [3:0] op; logic [5:0] rs, rd, rt;
    logic [14:0] imm; logic [31:0] w; bit bad;
    ri = 1'($urandom); op = 4'($urandom);
    rs = 6'($urandom); rd = 6'($urandom); rt = 6'($urandom);
    imm = 15'($urandom);
    if ($urandom_range(0, 3) == 0) op = 4'h0;
    if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) != 0) ? 4'h9 : 4'hb;
    if ($urandom_range(0, 1) == 0) begin
      rd = rs;
      rt = rs;
    end
    ref_enc(ri, op, rs, rd, rt, imm, w, bad);
    send_exp(ri, op, rs, rd, rt, imm, w, bad);
  endtask

  // monitor: compares every issued word against the scoreboard head
  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst = 32'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_stable", out_inst, prev_inst);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
`ifdef INST_ENC_NOP_FILL_EN
          chk("filler_nop", out_inst, 32'h0);
`else
          chk("unexpected_issue", out_inst, 32'hxxxx_xxxx);
`endif
        end else begin
          chk("issue_word", out_inst, expq.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready && (expq.size() != 0);
      prev_inst = out_inst;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && expq.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("drain_empty", expq.size(), 0);
    chk("drain_level", {29'h0, level}, 0);
  endtask

  initial begin
    #12;
    chk("rst_level", {29'h0, level}, 0);
`ifdef INST_ENC_NOP_FILL_EN
    chk("rst_out_valid", {31'h0, out_valid}, 1);
`else
    chk("rst_out_valid", {31'h0, out_valid}, 0);
`endif
    chk("rst_out_inst", out_inst, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_err_cnt", {24'h0, err_cnt}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    send_exp(0, 4'h2, 3, 5, 7, 15'h0, 32'h0629_0E00, 0);
    @(posedge clk); #1;
    chk("level_back_0", {29'h0, level}, 0);
    send_exp(1, 4'h3, 1, 2, 0, 15'h1234, 32'h8211_9234, 0);
    send_exp(0, 4'h9, 4, 4, 9, 15'h0, 32'h1224_8000, 0);
    send_exp(0, 4'hb, 6, 0, 8, 15'h0, 32'h0, 1);
    @(posedge clk); #1;
    chk("err_one_cycle", {31'h0, err}, 0);
    chk("err_cnt_one", {24'h0, err_cnt}, 1);
    send_exp(1, 4'h0, 9, 9, 9, 15'h7fff, 32'h0, 0);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    mcnt = 0;
    chk("clr_err", {24'h0, err_cnt}, 0);
    drain();

    // fill to DEPTH, hold a fifth set, then release across the wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_exp(0, 4'h1, 6'(i), 6'(i + 1), 6'(i + 2), 15'h0,
               {1'b0, 6'(i), 6'(i + 1), 4'h1, 6'(i + 2), 9'h0}, 0);
    drive(1, 4'h5, 10, 11, 12, 15'h0abc);
    repeat (3) @(posedge clk);
    #1;
    chk("full_level", {29'h0, level}, 4);
    chk("full_in_ready", {31'h0, in_ready}, 0);
    out_ready = 1'b1;
    finish_send({1'b1, 6'd10, 6'd11, 4'h5, 15'h0abc}, 0);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    drain();

    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    mcnt = 0;
    for (int i = 0; i < 300; i++)
      send_exp(0, 4'h9, 6'd1, 6'd2, 6'(i), 15'h0, 32'h0, 1);
    chk("err_cnt_sat", {24'h0, err_cnt}, 255);
    chk("sat_no_issue", expq.size(), 0);

    // async reset with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_exp(1, 4'h7, 6'(i), 6'(i), 6'(i), 15'(i * 3),
               {1'b1, 6'(i), 6'(i), 4'h7, 15'(i * 3)}, 0);
    chk("pre_rst_level", {29'h0, level}, 3);
    #2;
    rst_n = 1'b0;
    #1;
    expq.delete();
    mcnt = 0;
    chk("async_level", {29'h0, level}, 0);
`ifdef INST_ENC_NOP_FILL_EN
    chk("async_out_valid", {31'h0, out_valid}, 1);
`else
    chk("async_out_valid", {31'h0, out_valid}, 0);
`endif
    chk("async_out_inst", out_inst, 0);
    chk("async_err_cnt", {24'h0, err_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_exp(0, 4'h4, 2, 3, 4, 15'h0, {1'b0, 6'd2, 6'd3, 4'h4, 6'd4, 9'h0}, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
